// File: rtl/mouse_vga_top.sv
// mouse_vga_top: PS/2 mouse init and packet decode,
// cursor on 640x480 VGA, X/Y on 7-seg, buttons on LEDs.
module mouse_vga_top (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SWITCH,
  inout  wire         CLK_MOUSE,
  inout  wire         DATA_MOUSE,
  output logic [3:0]  SEG_SELECT,
  output logic [7:0]  HEX_OUT,
  output logic [15:0] LED_OUT,
  output logic        HS,
  output logic        VS,
  output logic [7:0]  COLOUR_OUT
);

  typedef enum logic [2:0] {
    IDLE_WAIT,
    INHIBIT,
    REQ,
    SEND,
    WAIT_ACK,
    WAIT_FA,
    STREAM
  } state_t;

  localparam logic [7:0] CMD = 8'hF4;

  logic [1:0]  div_q, div_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [2:0]  ck_q, ck_d;
  logic [1:0]  dt_q, dt_d;
  logic        fall, dat_s;
  logic        rx_en;
  logic [10:0] rx_sh_q, rx_sh_d, frame;
  logic [3:0]  rx_cnt_q, rx_cnt_d;
  logic [17:0] rx_tmo_q, rx_tmo_d;
  logic        rx_vld_q, rx_vld_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  state_t      st_q, st_d;
  logic [20:0] tmr_q, tmr_d;
  logic [3:0]  tx_idx_q, tx_idx_d;
  logic        tx_q, tx_d;
  logic        clk_oe, dat_oe;
  logic [1:0]  pk_q, pk_d;
  logic [6:0]  hdr_q, hdr_d;
  logic [7:0]  dx_q, dx_d;
  logic [17:0] gap_q, gap_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [2:0]  btn_q, btn_d;
  logic signed [10:0] nx, ny;
  logic [17:0] sc_q, sc_d;
  logic [3:0]  nib;

  // pixel-rate divider and raster counters
  always_comb begin
    div_d  = div_q + 2'd1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (div_q == 2'd3) begin
      if (hcnt_q == 10'd799) begin
        hcnt_d = 10'd0;
        if (vcnt_q == 10'd524) vcnt_d = 10'd0;
        else vcnt_d = vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  // sync pulses and pixel colour
  always_comb begin
    HS = !(hcnt_q >= 10'd656 && hcnt_q <= 10'd751);
    VS = !(vcnt_q >= 10'd490 && vcnt_q <= 10'd491);
    COLOUR_OUT = 8'h00;
    if (hcnt_q < 10'd640 && vcnt_q < 10'd480) begin
      if (hcnt_q[9:2] == x_q && vcnt_q[9:2] == y_q)
        COLOUR_OUT = SWITCH ? 8'h1F : 8'hE0;
      else
        COLOUR_OUT = SWITCH ? 8'hFC : 8'h03;
    end
  end

  // two-stage line synchronisers plus previous clock level
  always_comb begin
    ck_d = {ck_q[1:0], CLK_MOUSE};
    dt_d = {dt_q[0], DATA_MOUSE};
  end

  assign fall  = ck_q[2] & ~ck_q[1];
  assign dat_s = dt_q[1];
  assign rx_en = (st_q == WAIT_FA) || (st_q == STREAM);

  // device-to-host frame receiver with inter-edge timeout
  always_comb begin
    rx_sh_d   = rx_sh_q;
    rx_cnt_d  = rx_cnt_q;
    rx_tmo_d  = rx_tmo_q;
    rx_vld_d  = 1'b0;
    rx_byte_d = rx_byte_q;
    frame     = {dat_s, rx_sh_q[10:1]};
    if (!rx_en) begin
      rx_cnt_d = 4'd0;
      rx_tmo_d = 18'd0;
    end else if (fall) begin
      rx_tmo_d = 18'd0;
      rx_sh_d  = frame;
      if (rx_cnt_q == 4'd10) begin
        rx_cnt_d  = 4'd0;
        rx_vld_d  = ~frame[0] & frame[10] & (^frame[9:1]);
        rx_byte_d = frame[8:1];
      end else begin
        rx_cnt_d = rx_cnt_q + 4'd1;
      end
    end else if (rx_cnt_q != 4'd0) begin
      if (rx_tmo_q == 18'd199_999) begin
        rx_cnt_d = 4'd0;
        rx_tmo_d = 18'd0;
      end else begin
        rx_tmo_d = rx_tmo_q + 18'd1;
      end
    end
  end

  // init sequence: inhibit, request, send F4, ack, await FA
  always_comb begin
    st_d     = st_q;
    tmr_d    = tmr_q + 21'd1;
    tx_idx_d = tx_idx_q;
    tx_d     = tx_q;
    clk_oe   = 1'b0;
    dat_oe   = 1'b0;
    unique case (st_q)
      IDLE_WAIT: if (tmr_q == 21'd999_999) st_d = INHIBIT;
      INHIBIT: begin
        clk_oe = 1'b1;
        if (tmr_q == 21'd9_999) st_d = REQ;
      end
      REQ: begin
        clk_oe   = 1'b1;
        dat_oe   = 1'b1;
        tx_d     = 1'b0;
        tx_idx_d = 4'd0;
        st_d     = SEND;
      end
      SEND: begin
        dat_oe = ~tx_q;
        if (fall) begin
          tx_idx_d = tx_idx_q + 4'd1;
          if (tx_idx_q < 4'd8) begin
            tx_d = CMD[tx_idx_q[2:0]];
          end else if (tx_idx_q == 4'd8) begin
            tx_d = 1'b0;
          end else begin
            tx_d = 1'b1;
            st_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: if (fall && !dat_s) st_d = WAIT_FA;
      WAIT_FA: begin
        if (rx_vld_q && rx_byte_q == 8'hFA) st_d = STREAM;
      end
      default: tmr_d = tmr_q;
    endcase
    if (st_q inside {REQ, SEND, WAIT_ACK, WAIT_FA}) begin
      if (fall) tmr_d = 21'd0;
      if (tmr_q == 21'd1_999_999) st_d = INHIBIT;
    end
    if (st_d != st_q) tmr_d = 21'd0;
  end

  assign CLK_MOUSE  = clk_oe ? 1'b0 : 1'bz;
  assign DATA_MOUSE = dat_oe ? 1'b0 : 1'bz;

  // 3-byte packet assembly and clamped cursor update
  always_comb begin
    pk_d  = pk_q;
    hdr_d = hdr_q;
    dx_d  = dx_q;
    gap_d = gap_q;
    x_d   = x_q;
    y_d   = y_q;
    btn_d = btn_q;
    nx = $signed({3'b000, x_q}) + $signed({{3{hdr_q[3]}}, dx_q});
    ny = $signed({3'b000, y_q}) - $signed({{3{hdr_q[4]}}, rx_byte_q});
    if (gap_q != 18'd200_000) gap_d = gap_q + 18'd1;
    if (st_q == STREAM && rx_vld_q) begin
      gap_d = 18'd0;
      unique case (pk_q)
        2'd0: begin
          if (rx_byte_q[3]) begin
            hdr_d = {rx_byte_q[7:4], rx_byte_q[2:0]};
            pk_d  = 2'd1;
          end
        end
        2'd1: begin
          dx_d = rx_byte_q;
          pk_d = 2'd2;
        end
        default: begin
          pk_d  = 2'd0;
          btn_d = hdr_q[2:0];
          if (!hdr_q[5]) begin
            if (nx < 11'sd0) x_d = 8'd0;
            else if (nx > 11'sd159) x_d = 8'd159;
            else x_d = nx[7:0];
          end
          if (!hdr_q[6]) begin
            if (ny < 11'sd0) y_d = 8'd0;
            else if (ny > 11'sd119) y_d = 8'd119;
            else y_d = ny[7:0];
          end
        end
      endcase
    end else if (gap_q == 18'd200_000) begin
      pk_d = 2'd0;
    end
  end

  // digit scan and hex font
  always_comb begin
    sc_d       = sc_q + 18'd1;
    SEG_SELECT = 4'b1111;
    nib        = 4'h0;
    HEX_OUT    = 8'hFF;
    unique case (sc_q[17:16])
      2'd0: begin SEG_SELECT = 4'b0111; nib = x_q[7:4]; end
      2'd1: begin SEG_SELECT = 4'b1011; nib = x_q[3:0]; end
      2'd2: begin SEG_SELECT = 4'b1101; nib = y_q[7:4]; end
      default: begin SEG_SELECT = 4'b1110; nib = y_q[3:0]; end
    endcase
    unique case (nib)
      4'h0: HEX_OUT = 8'hC0;
      4'h1: HEX_OUT = 8'hF9;
      4'h2: HEX_OUT = 8'hA4;
      4'h3: HEX_OUT = 8'hB0;
      4'h4: HEX_OUT = 8'h99;
      4'h5: HEX_OUT = 8'h92;
      4'h6: HEX_OUT = 8'h82;
      4'h7: HEX_OUT = 8'hF8;
      4'h8: HEX_OUT = 8'h80;
      4'h9: HEX_OUT = 8'h90;
      4'hA: HEX_OUT = 8'h88;
      4'hB: HEX_OUT = 8'h83;
      4'hC: HEX_OUT = 8'hC6;
      4'hD: HEX_OUT = 8'hA1;
      4'hE: HEX_OUT = 8'h86;
      default: HEX_OUT = 8'h8E;
    endcase
  end

  assign LED_OUT = {st_q == STREAM, 12'b0, btn_q};

  // state registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_q     <= 2'd0;
      hcnt_q    <= 10'd0;
      vcnt_q    <= 10'd0;
      ck_q      <= 3'b111;
      dt_q      <= 2'b11;
      rx_sh_q   <= 11'd0;
      rx_cnt_q  <= 4'd0;
      rx_tmo_q  <= 18'd0;
      rx_vld_q  <= 1'b0;
      rx_byte_q <= 8'd0;
      st_q      <= IDLE_WAIT;
      tmr_q     <= 21'd0;
      tx_idx_q  <= 4'd0;
      tx_q      <= 1'b1;
      pk_q      <= 2'd0;
      hdr_q     <= 7'd0;
      dx_q      <= 8'd0;
      gap_q     <= 18'd0;
      x_q       <= 8'd80;
      y_q       <= 8'd60;
      btn_q     <= 3'd0;
      sc_q      <= 18'd0;
    end else begin
      div_q     <= div_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      ck_q      <= ck_d;
      dt_q      <= dt_d;
      rx_sh_q   <= rx_sh_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_tmo_q  <= rx_tmo_d;
      rx_vld_q  <= rx_vld_d;
      rx_byte_q <= rx_byte_d;
      st_q      <= st_d;
      tmr_q     <= tmr_d;
      tx_idx_q  <= tx_idx_d;
      tx_q      <= tx_d;
      pk_q      <= pk_d;
      hdr_q     <= hdr_d;
      dx_q      <= dx_d;
      gap_q     <= gap_d;
      x_q       <= x_d;
      y_q       <= y_d;
      btn_q     <= btn_d;
      sc_q      <= sc_d;
    end
  end

endmodule

// File: tb/tb_mouse_vga_top.sv
// tb_mouse_vga_top: PS/2 mouse model driving mouse_vga_top,
// VGA timing, init handshake, packet decode and display checks.
`timescale 1ns/1ps
module tb_mouse_vga_top;

  localparam int HALF = 25;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        SWITCH = 1'b0;
  wire         ps2_clk;
  wire         ps2_dat;
  logic [3:0]  SEG_SELECT;
  logic [7:0]  HEX_OUT;
  logic [15:0] LED_OUT;
  logic        HS, VS;
  logic [7:0]  COLOUR_OUT;

  logic dev_clk_lo = 1'b0;
  logic dev_dat_lo = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_lo ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_lo ? 1'b0 : 1'bz;

  mouse_vga_top dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SWITCH     (SWITCH),
    .CLK_MOUSE  (ps2_clk),
    .DATA_MOUSE (ps2_dat),
    .SEG_SELECT (SEG_SELECT),
    .HEX_OUT    (HEX_OUT),
    .LED_OUT    (LED_OUT),
    .HS         (HS),
    .VS         (VS),
    .COLOUR_OUT (COLOUR_OUT)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
                            8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83,
                            8'hC6, 8'hA1, 8'h86, 8'h8E};

  int         mx = 80;
  int         my = 60;
  logic [2:0] mbtn = 3'd0;
  logic [31:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int unsigned obs,
                         input int unsigned lo, input int unsigned hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [31:0] exp_state();
    logic [7:0] ex, ey;
    ex = 8'(mx);
    ey = 8'(my);
    return {ex, ey, 1'b1, 12'b0, mbtn};
  endfunction

  function automatic logic [31:0] obs_state();
    return {dut.x_q, dut.y_q, LED_OUT};
  endfunction

  task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
    int dx, dy;
    dx = b0[4] ? int'(b1) - 256 : int'(b1);
    dy = b0[5] ? int'(b2) - 256 : int'(b2);
    if (!b0[6]) mx = clampi(mx + dx, 159);
    if (!b0[7]) my = clampi(my - dy, 119);
    mbtn = b0[2:0];
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      dev_dat_lo = ~fr[i];
      repeat (HALF) @(negedge CLK);
      dev_clk_lo = 1'b1;
      repeat (HALF) @(negedge CLK);
      dev_clk_lo = 1'b0;
    end
    dev_dat_lo = 1'b0;
    repeat (HALF) @(negedge CLK);
  endtask

  task automatic send3(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic bad0);
    send_byte(b0, bad0);
    repeat (100) @(negedge CLK);
    send_byte(b1, 1'b0);
    repeat (100) @(negedge CLK);
    send_byte(b2, 1'b0);
    repeat (20) @(negedge CLK);
  endtask

  task automatic pkt(input string tag, input logic [7:0] b0,
                     input logic [7:0] b1, input logic [7:0] b2);
    model_pkt(b0, b1, b2);
    sb.push_back(exp_state());
    send3(b0, b1, b2, 1'b0);
    chk(tag, obs_state(), sb.pop_front());
  endtask

  task automatic no_move(input string tag, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2,
                         input logic bad0);
    sb.push_back(exp_state());
    send3(b0, b1, b2, bad0);
    chk(tag, obs_state(), sb.pop_front());
  endtask

  initial begin
    int unsigned t0, t1, n;
    logic [9:0]  bits;
    logic [7:0]  rxb;
    logic [3:0]  sel;
    logic [7:0]  xv, yv;
    logic [3:0]  en;

    #90;
    chk("rst_hs", 32'(HS), 32'd1);
    chk("rst_vs", 32'(VS), 32'd1);
    chk("rst_colour_sw0", 32'(COLOUR_OUT), 32'h03);
    chk("rst_seg_sel", 32'(SEG_SELECT), 32'h7);
    chk("rst_hex", 32'(HEX_OUT), 32'h92);
    chk("rst_led", 32'(LED_OUT), 32'h0);
    chk("rst_ps2_lines", 32'({ps2_clk, ps2_dat}), 32'h3);
    SWITCH = 1'b1;
    #1;
    chk("rst_colour_sw1", 32'(COLOUR_OUT), 32'hFC);
    SWITCH = 1'b0;

    @(negedge CLK);
    RESET = 1'b1;
    t0 = cyc;

    n = 0;
    while (HS && n < 5000) begin @(negedge CLK); n++; end
    t1 = cyc;
    chk("hs_first_fall", t1 - t0, 32'd2624);
    repeat (176) @(negedge CLK);
    chk("colour_h700", 32'(COLOUR_OUT), 32'h00);
    n = 0;
    while (!HS && n < 5000) begin @(negedge CLK); n++; end
    chk("hs_low_width", cyc - t1, 32'd384);
    n = 0;
    while (HS && n < 5000) begin @(negedge CLK); n++; end
    chk("line_period", cyc - t1, 32'd3200);

    sb.push_back(32'hF4);
    n = 0;
    while (ps2_clk !== 1'b0 && n < 1_100_000) begin @(negedge CLK); n++; end
    chk_rng("inhibit_start", cyc - t0, 1_000_000, 1_000_002);
    t1 = cyc;
    n = 0;
    while (ps2_clk !== 1'b1 && n < 20_000) begin @(negedge CLK); n++; end
    chk_rng("inhibit_len", cyc - t1, 10_000, 10_003);
    chk("req_data_low", 32'(ps2_dat), 32'd0);

    repeat (HALF) @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      dev_clk_lo = 1'b1;
      repeat (HALF) @(negedge CLK);
      dev_clk_lo = 1'b0;
      repeat (HALF) @(negedge CLK);
      bits[i] = ps2_dat;
    end
    dev_dat_lo = 1'b1;
    repeat (HALF) @(negedge CLK);
    dev_clk_lo = 1'b1;
    repeat (HALF) @(negedge CLK);
    dev_clk_lo = 1'b0;
    repeat (HALF) @(negedge CLK);
    dev_dat_lo = 1'b0;
    rxb = bits[7:0];
    chk("host_byte", 32'(rxb), sb.pop_front());
    chk("host_parity", 32'(bits[8]), 32'd0);
    chk("host_stop", 32'(bits[9]), 32'd1);

    repeat (50) @(negedge CLK);
    send_byte(8'hFA, 1'b0);
    repeat (20) @(negedge CLK);
    chk("stream_led", 32'(LED_OUT[15]), 32'd1);

    pkt("pkt_left_move", 8'h09, 8'h05, 8'h03);

    xv = 8'(mx);
    yv = 8'(my);
    for (int d = 3; d >= 0; d--) begin
      sel = 4'b1111;
      sel[d] = 1'b0;
      unique case (d)
        3: en = xv[7:4];
        2: en = xv[3:0];
        1: en = yv[7:4];
        default: en = yv[3:0];
      endcase
      n = 0;
      while (SEG_SELECT !== sel && n < 300_000) begin
        @(negedge CLK);
        n++;
      end
      chk($sformatf("seg_sel_%0d", d), 32'(SEG_SELECT), 32'(sel));
      chk($sformatf("seg_hex_%0d", d), 32'(HEX_OUT), 32'(font[en]));
    end

    pkt("pkt_x_clamp0", 8'h18, 8'h00, 8'h00);
    pkt("pkt_x_clamp0_again", 8'h18, 8'h00, 8'h00);
    no_move("bad_parity", 8'h09, 8'h05, 8'h03, 1'b1);
    no_move("bit3_zero", 8'h01, 8'h05, 8'h03, 1'b0);
    pkt("pkt_after_bad", 8'h2A, 8'h10, 8'hF0);
    pkt("pkt_x_overflow", 8'h4B, 8'h20, 8'h01);
    pkt("pkt_y_clamp0", 8'h08, 8'h00, 8'h7F);
    pkt("pkt_x_clamp159", 8'h08, 8'hFF, 8'h00);

    n = 0;
    while (VS && n < 2_000_000) begin @(negedge CLK); n++; end
    t1 = cyc;
    chk("vs_first_fall", t1 - t0, 32'd1_568_000);
    n = 0;
    while (!VS && n < 20_000) begin @(negedge CLK); n++; end
    chk("vs_low_width", cyc - t1, 32'd6400);

    RESET = 1'b0;
    #1;
    chk("midrst_lines", 32'({ps2_clk, ps2_dat}), 32'h3);
    chk("midrst_led", 32'(LED_OUT), 32'h0);
    chk("midrst_xy", 32'({dut.x_q, dut.y_q}), 32'h503C);
    chk("midrst_hex", 32'(HEX_OUT), 32'h92);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
